// File: rtl/key_event_unit.sv
// Purpose: per-key synchroniser, debouncer and press/release/click/long/repeat event classifier.
// Latency: raw edge to held/press/release is DB_CYC+2 clk edges; every event output is registered.
// Backpressure: none; pulses are single-cycle and consumers must sample them every cycle.
module key_event_unit #(
    parameter int NUM_KEYS    = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_HZ   = 10,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] held,
    output logic [NUM_KEYS-1:0] press,
    // release and repeat are reserved words, hence the _pulse names
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] click,
    output logic [NUM_KEYS-1:0] long_press,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
    localparam int REP_CYC  = CLK_HZ / REPEAT_HZ;

    localparam int DB_W   = $clog2(DB_CYC);
    localparam int LONG_W = $clog2(LONG_CYC);
    localparam int REP_W  = $clog2(REP_CYC);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYC - 1);

    // Every terminal count must leave at least one counting cycle.
    if (DB_CYC < 2 || LONG_CYC < 2 || REP_CYC < 2) begin : g_param_check
        $error("key_event_unit: DB_CYC, LONG_CYC and REP_CYC must each be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic              key_lvl;
        logic              sync1;
        logic              sync2;
        logic              deb;
        logic [DB_W-1:0]   db_cnt;
        logic              db_done;
        logic              deb_rise;
        logic              deb_fall;
        state_t            state;
        logic [LONG_W-1:0] hold_cnt;
        logic [REP_W-1:0]  rep_cnt;
        logic              press_q;
        logic              release_q;
        logic              click_q;
        logic              long_q;
        logic              repeat_q;

        // Normalise so that 1 always means "pressed" from here on.
        assign key_lvl = (ACTIVE_LOW != 0) ? ~key_in[k] : key_in[k];

        // The debounced level flips on this edge; the FSM reacts on the same
        // edge so that press/release line up with held.
        assign db_done  = (sync2 != deb) && (db_cnt == DB_LAST);
        assign deb_rise = db_done && sync2;
        assign deb_fall = db_done && !sync2;

        // Two-flop synchroniser followed by a stability counter.
        always_ff @(posedge clk) begin
            if (!reset) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                deb    <= 1'b0;
                db_cnt <= '0;
            end else begin
                sync1 <= key_lvl;
                sync2 <= sync1;
                if (sync2 == deb) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    deb    <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        // Event FSM: release always wins over a coincident long/repeat terminal count.
        always_ff @(posedge clk) begin
            if (!reset) begin
                state     <= ST_IDLE;
                hold_cnt  <= '0;
                rep_cnt   <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                click_q   <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                click_q   <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (deb_rise) begin
                            state    <= ST_PRESSED;
                            press_q  <= 1'b1;
                            hold_cnt <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (deb_fall) begin
                            state     <= ST_IDLE;
                            release_q <= 1'b1;
                            click_q   <= 1'b1;
                        end else if (hold_cnt == LONG_LAST) begin
                            state   <= ST_LONG;
                            long_q  <= 1'b1;
                            rep_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    ST_LONG: begin
                        if (deb_fall) begin
                            state     <= ST_IDLE;
                            release_q <= 1'b1;
                        end else if (!repeat_en[k]) begin
                            // Parked at zero so re-enabling waits a full period.
                            rep_cnt <= '0;
                        end else if (rep_cnt == REP_LAST) begin
                            repeat_q <= 1'b1;
                            rep_cnt  <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end

        assign held[k]          = deb;
        assign press[k]         = press_q;
        assign release_pulse[k] = release_q;
        assign click[k]         = click_q;
        assign long_press[k]    = long_q;
        assign repeat_pulse[k]  = repeat_q;
    end

endmodule

// File: tb/tb_key_event_unit.sv
// Bench for key_event_unit: directed scenarios followed by a random key-bashing phase.
// A timestamp-based event model predicts every output on every cycle.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_key_event_unit;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int LG = 20;
    localparam int RP = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_in;
    logic [NK-1:0] repeat_en;
    logic [NK-1:0] held;
    logic [NK-1:0] press;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] click;
    logic [NK-1:0] long_press;
    logic [NK-1:0] repeat_pulse;

    // Physical view: 1 = finger on the key; the board key reads low when pressed.
    logic [NK-1:0] pressed;
    assign key_in = ~pressed;

    always #5 clk = ~clk;

    key_event_unit #(
        .NUM_KEYS   (NK),
        .CLK_HZ     (1000),
        .DEBOUNCE_MS(4),
        .LONG_MS    (20),
        .REPEAT_HZ  (200),
        .ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_in       (key_in),
        .repeat_en    (repeat_en),
        .held         (held),
        .press        (press),
        .release_pulse(release_pulse),
        .click        (click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model state (per key)
    bit m_h1[NK];
    bit m_h2[NK];
    bit m_deb[NK];
    int m_run[NK];
    bit m_down[NK];
    bit m_long[NK];
    int m_press_t[NK];
    int m_rep_ref[NK];

    logic [NK-1:0] e_held, e_press, e_rel, e_click, e_long, e_rep;

    // Observed event log: index 0 press, 1 release, 2 click, 3 long, 4 repeat
    int last_t[NK][5];
    int ev_n[NK][5];
    int rep_times[$];

    int tf, p0, rr;
    int dur[NK];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model step for one rising edge, using the inputs as they were at the edge.
    function automatic void model_edge();
        bit seen, rose, fell;
        e_held  = '0;
        e_press = '0;
        e_rel   = '0;
        e_click = '0;
        e_long  = '0;
        e_rep   = '0;
        for (int k = 0; k < NK; k++) begin
            if (!reset) begin
                m_h1[k] = 0; m_h2[k] = 0; m_deb[k] = 0; m_run[k] = 0;
                m_down[k] = 0; m_long[k] = 0;
            end else begin
                // level seen by the debouncer is the one sampled two edges ago
                seen    = m_h2[k];
                m_h2[k] = m_h1[k];
                m_h1[k] = pressed[k];
                rose = 0;
                fell = 0;
                if (seen != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_deb[k] = seen;
                        m_run[k] = 0;
                        rose = seen;
                        fell = !seen;
                    end
                end else begin
                    m_run[k] = 0;
                end
                if (rose) begin
                    m_down[k] = 1; m_long[k] = 0; m_press_t[k] = cyc; e_press[k] = 1'b1;
                end else if (fell) begin
                    e_rel[k]   = 1'b1;
                    e_click[k] = !m_long[k];
                    m_down[k]  = 0;
                    m_long[k]  = 0;
                end else if (m_down[k] && !m_long[k]) begin
                    if (cyc - m_press_t[k] == LG) begin
                        m_long[k] = 1; m_rep_ref[k] = cyc; e_long[k] = 1'b1;
                    end
                end else if (m_long[k]) begin
                    if (!repeat_en[k]) m_rep_ref[k] = cyc;
                    else if (cyc - m_rep_ref[k] == RP) begin
                        e_rep[k] = 1'b1; m_rep_ref[k] = cyc;
                    end
                end
            end
            e_held[k] = m_deb[k];
        end
    endfunction

    function automatic void clear_ev();
        for (int k = 0; k < NK; k++)
            for (int j = 0; j < 5; j++) begin
                last_t[k][j] = -1;
                ev_n[k][j]   = 0;
            end
        rep_times.delete();
    endfunction

    task automatic tick();
        logic [4:0] evv;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("held", 32'(held), 32'(e_held));
        chk("press", 32'(press), 32'(e_press));
        chk("release", 32'(release_pulse), 32'(e_rel));
        chk("click", 32'(click), 32'(e_click));
        chk("long_press", 32'(long_press), 32'(e_long));
        chk("repeat", 32'(repeat_pulse), 32'(e_rep));
        for (int k = 0; k < NK; k++) begin
            evv = {repeat_pulse[k], long_press[k], click[k], release_pulse[k], press[k]};
            for (int j = 0; j < 5; j++)
                if (evv[j]) begin
                    last_t[k][j] = cyc;
                    ev_n[k][j]++;
                end
            if (k == 0 && repeat_pulse[0]) rep_times.push_back(cyc);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int j;
        reset     = 1'b0;
        pressed   = '0;
        repeat_en = '0;
        clear_ev();
        run(3);
        chk("reset_state", 32'({held, press, release_pulse, click, long_press, repeat_pulse}), 32'd0);
        reset = 1'b1;
        run(10);

        // Bounce: 3-cycle glitch must be swallowed
        clear_ev();
        pressed[0] = 1'b1;
        run(3);
        pressed[0] = 1'b0;
        run(10);
        chk("bounce_no_press", 32'(ev_n[0][0]), 32'd0);
        chk("bounce_held", 32'(held[0]), 32'd0);

        // Real press: press 6 cycles after raw edge
        pressed[0] = 1'b1;
        tf = cyc;
        run(10);
        chk("press_lat", 32'(last_t[0][0]), 32'(tf + 6));
        chk("press_cnt", 32'(ev_n[0][0]), 32'd1);
        chk("press_held", 32'(held[0]), 32'd1);

        // Short click
        pressed[0] = 1'b0;
        tf = cyc;
        run(10);
        chk("click_rel_t", 32'(last_t[0][1]), 32'(tf + 6));
        chk("click_t", 32'(last_t[0][2]), 32'(tf + 6));
        chk("click_no_long", 32'(ev_n[0][3]), 32'd0);

        // Long press with auto-repeat
        clear_ev();
        repeat_en[0] = 1'b1;
        pressed[0]   = 1'b1;
        tf = cyc;
        run(6);
        p0 = tf + 6;
        run(40);
        chk("long_t", 32'(last_t[0][3]), 32'(p0 + 20));
        chk("rep_cnt", 32'(rep_times.size()), 32'd4);
        for (int i = 0; i < rep_times.size() && i < 4; i++)
            chk("rep_t", 32'(rep_times[i]), 32'(p0 + 25 + 5 * i));
        pressed[0] = 1'b0;
        run(10);
        chk("long_rel_cnt", 32'(ev_n[0][1]), 32'd1);
        chk("long_no_click", 32'(ev_n[0][2]), 32'd0);

        // Repeat disabled, then enabled mid-hold
        clear_ev();
        repeat_en[0] = 1'b0;
        pressed[0]   = 1'b1;
        tf = cyc;
        run(6);
        p0 = tf + 6;
        run(30);
        chk("dis_long_t", 32'(last_t[0][3]), 32'(p0 + 20));
        chk("dis_no_rep", 32'(ev_n[0][4]), 32'd0);
        repeat_en[0] = 1'b1;
        run(5);
        chk("en_rep_cnt", 32'(ev_n[0][4]), 32'd1);
        chk("en_rep_t", 32'(last_t[0][4]), 32'(p0 + 35));
        pressed[0] = 1'b0;
        run(10);
        repeat_en[0] = 1'b0;

        // Two keys together; key1 released on its long terminal cycle
        clear_ev();
        pressed = 2'b11;
        tf = cyc;
        run(6);
        p0 = tf + 6;
        chk("dual_press0", 32'(last_t[0][0]), 32'(p0));
        chk("dual_press1", 32'(last_t[1][0]), 32'(p0));
        run(14);
        pressed[1] = 1'b0;
        run(6);
        chk("prio_rel1", 32'(last_t[1][1]), 32'(p0 + 20));
        chk("prio_click1", 32'(last_t[1][2]), 32'(p0 + 20));
        chk("prio_nolong1", 32'(ev_n[1][3]), 32'd0);
        chk("indep_long0", 32'(last_t[0][3]), 32'(p0 + 20));
        chk("indep_norel0", 32'(ev_n[0][1]), 32'd0);
        pressed[0] = 1'b0;
        run(10);

        // Reset while in long-press state
        clear_ev();
        repeat_en[0] = 1'b1;
        pressed[0]   = 1'b1;
        run(28);
        reset = 1'b0;
        run(1);
        rr = cyc;
        chk("rst_outs", 32'({held, press, release_pulse, click, long_press, repeat_pulse}), 32'd0);
        reset = 1'b1;
        clear_ev();
        run(6);
        chk("rst_repress_t", 32'(last_t[0][0]), 32'(rr + 6));
        run(20);
        chk("rst_long_t", 32'(last_t[0][3]), 32'(rr + 26));
        pressed   = '0;
        repeat_en = '0;
        run(10);

        // Random key bashing, repeat toggling and occasional resets
        for (int k = 0; k < NK; k++) dur[k] = $urandom_range(1, 30);
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NK; k++) begin
                if (dur[k] == 0) begin
                    pressed[k] = ~pressed[k];
                    dur[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 60);
                end else begin
                    dur[k]--;
                end
            end
            if ($urandom_range(0, 29) == 0) begin
                j = $urandom_range(0, NK - 1);
                repeat_en[j] = ~repeat_en[j];
            end
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
